// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// datapath mux selects, ALU operation classes and ALU control codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, JAL, JALR, JALR2, BRANCH, LUI, AUIPC, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // Immediate format is a pure function of the opcode, independent of state.
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's ALU operation class plus the
// instruction's funct fields onto a concrete ALU control code.
module aludec
  import riscv_ctrl_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  aluop_t     aluop,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type has a sub; in OP-IMM instr[30] is an immediate bit.
          3'b000:  alu_control = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM sequencing a shared-ALU, shared-memory
// datapath, with a memory handshake, retired-instruction counter and trap.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       AccessMode,
  output logic             DataExtendMode,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstRet
);

  state_t state, next_state;
  aluop_t aluop;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (MemReady) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_R:              next_state = EXECR;
          OP_I:              next_state = EXECI;
          OP_JAL:            next_state = JAL;
          OP_JALR:           next_state = JALR;
          OP_LUI:            next_state = LUI;
          OP_AUIPC:          next_state = AUIPC;
          OP_BRANCH:         next_state = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
          default:           next_state = TRAP;
        endcase
      end
      MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (MemReady) next_state = MEMWB;
      MEMWRITE: if (MemReady) next_state = FETCH;
      EXECR, EXECI, JAL, JALR2: next_state = ALUWB;
      JALR:     next_state = JALR2;
      MEMWB, ALUWB, BRANCH, LUI, AUIPC: next_state = FETCH;
      TRAP:     next_state = TRAP;
      default:  next_state = FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no path through
  // this block leaves a signal unassigned and infers a latch.
  always_comb begin
    MemReq         = 1'b0;
    MemWrite       = 1'b0;
    AdrSrc         = 1'b0;
    IRWrite        = 1'b0;
    PCWrite        = 1'b0;
    RegWrite       = 1'b0;
    ResultSrc      = RES_ALUOUT;
    ALUSrcA        = SRCA_PC;
    ALUSrcB        = SRCB_RD2;
    aluop          = ALUOP_ADD;
    AccessMode     = 2'b00;
    DataExtendMode = 1'b0;
    Illegal        = 1'b0;
    case (state)
      FETCH: begin
        MemReq = 1'b1;
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
        end
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR, JALR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        MemReq         = 1'b1;
        AdrSrc         = 1'b1;
        AccessMode     = funct3[1:0];
        DataExtendMode = funct3[2];
      end
      MEMWB: begin
        ResultSrc = RES_READDATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        MemReq     = 1'b1;
        MemWrite   = 1'b1;
        AdrSrc     = 1'b1;
        AccessMode = funct3[1:0];
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        aluop   = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB, AUIPC: RegWrite = 1'b1;
      // Redirect PC to the target held in ALUOut while the ALU forms OldPC+4.
      JAL, JALR2: begin
        PCWrite = 1'b1;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
      end
      BRANCH: begin
        ALUSrcA = SRCA_RD1;
        aluop   = ALUOP_SUB;
        PCWrite = Zero ^ funct3[0];
      end
      LUI: begin
        ResultSrc = RES_IMMEXT;
        RegWrite  = 1'b1;
      end
      TRAP:    Illegal = 1'b1;
      default: ;
    endcase
  end

  assign ImmSrc = imm_src(op);

  aludec u_aludec (
    .opb5        (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .aluop       (aluop),
    .alu_control (ALUControl)
  );

  // An instruction retires on the edge that returns the FSM to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      InstRet <= '0;
    else if (state != FETCH && next_state == FETCH)
      InstRet <= InstRet + CNT_W'(1);
  end

endmodule
